ram_read_arbiter: RTL and testbench

Shares the single read port of the main pixel/strip RAM between two requesters: the HUB75 framebuffer fetch path (high priority) and the WS2812 strip reader (low priority). Arbitration is fixed-priority with a starvation guard, and each accepted read is tagged with its owner so returning data is routed back to the right requester. It sits between main_ram's read side and the fetch/strip engines, all in the sys_clk domain.

---
 rtl/hub75_pkg.sv | 19 +
 rtl/read_tag_pipe.sv | 38 +++
 rtl/ram_read_arbiter.sv | 154 +++++++++++++++
 tb/tb_ram_read_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg
// Shared definitions for the HUB75 / WS2812 RAM read path.
//   - OWNER_FB / OWNER_STRIP: the tag that routes a RAM read back to its requester
//   - DEFAULT_ADDR_W / DEFAULT_DATA_W: default geometry of the main pixel/strip RAM
//   - read_tag_t: one in-flight read marker {valid, owner}
package hub75_pkg;

   localparam logic OWNER_FB    = 1'b0;
   localparam logic OWNER_STRIP = 1'b1;

   localparam int DEFAULT_ADDR_W = 15;
   localparam int DEFAULT_DATA_W = 80;

   typedef struct packed {
      logic valid;
      logic owner;
   } read_tag_t;

endpackage

// File: rtl/read_tag_pipe.sv
// read_tag_pipe
// Delay line that carries the {valid, owner} tag of every issued RAM read so
// it reaches the tail in the same cycle as the matching RAM read data.
// Ports:
//   clk      in   clock (sys_clk domain)
//   rst      in   synchronous active-high reset, empties the line
//   tag_in   in   tag of the read issued this cycle (valid = ram_re)
//   tag_out  out  tag whose data is on ram_rdata this cycle
module read_tag_pipe
   import hub75_pkg::*;
#(
   parameter int RAM_LATENCY = 1
)(
   input  logic      clk,
   input  logic      rst,
   input  read_tag_t tag_in,
   output read_tag_t tag_out
);

   read_tag_t stage_r [RAM_LATENCY];

   // Shift tags one stage per cycle; reset discards every in-flight read.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RAM_LATENCY; i++) begin
            stage_r[i] <= {1'b0, OWNER_FB};
         end
      end else begin
         stage_r[0] <= tag_in;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign tag_out = stage_r[RAM_LATENCY-1];

endmodule

// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter
// Shares the single read port of the main pixel/strip RAM between the HUB75
// framebuffer fetch path (high priority) and the WS2812 strip reader (low
// priority). Fixed priority, with a streak counter that forces a strip grant
// after MAX_FB_STREAK consecutive fb grants while strip is waiting. Each
// issued read is tagged with its owner so the returned word is steered back.
// Ports:
//   sys_clk, rst                       clock, synchronous active-high reset
//   fb_req/fb_addr/fb_gnt              fb request handshake (gnt combinational)
//   fb_rdata/fb_rvalid                 fb return data and one-cycle valid
//   strip_req/strip_addr/strip_gnt     strip request handshake (gnt combinational)
//   strip_rdata/strip_rvalid           strip return data and one-cycle valid
//   ram_re/ram_raddr                   registered RAM read command
//   ram_rdata                          RAM data, RAM_LATENCY cycles after ram_re
module ram_read_arbiter
   import hub75_pkg::*;
#(
   parameter int ADDR_W        = DEFAULT_ADDR_W,
   parameter int DATA_W        = DEFAULT_DATA_W,
   parameter int RAM_LATENCY   = 1,
   parameter int MAX_FB_STREAK = 8
)(
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              fb_req,
   input  logic [ADDR_W-1:0] fb_addr,
   output logic              fb_gnt,
   output logic [DATA_W-1:0] fb_rdata,
   output logic              fb_rvalid,
   input  logic              strip_req,
   input  logic [ADDR_W-1:0] strip_addr,
   output logic              strip_gnt,
   output logic [DATA_W-1:0] strip_rdata,
   output logic              strip_rvalid,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [7:0] STREAK_MAX = 8'(MAX_FB_STREAK);

   logic [7:0]        streak_r;
   logic              streak_full_s;
   logic              fb_gnt_s;
   logic              strip_gnt_s;
   logic              ram_re_r;
   logic [ADDR_W-1:0] ram_raddr_r;
   logic              issue_owner_r;
   read_tag_t         issue_tag_s;
   read_tag_t         tail_tag_s;
   logic              tail_fb_s;
   logic              tail_strip_s;
   logic              fb_rvalid_r;
   logic              strip_rvalid_r;
   logic [DATA_W-1:0] fb_rdata_r;
   logic [DATA_W-1:0] strip_rdata_r;

   assign streak_full_s = (streak_r >= STREAK_MAX);

   // Fixed-priority grant: fb wins a tie unless strip has waited a full streak.
   always_comb begin
      fb_gnt_s    = 1'b0;
      strip_gnt_s = 1'b0;
      if (rst) begin
         fb_gnt_s    = 1'b0;
         strip_gnt_s = 1'b0;
      end else if (fb_req && strip_req) begin
         if (streak_full_s) begin
            strip_gnt_s = 1'b1;
         end else begin
            fb_gnt_s = 1'b1;
         end
      end else if (fb_req) begin
         fb_gnt_s = 1'b1;
      end else if (strip_req) begin
         strip_gnt_s = 1'b1;
      end else begin
         fb_gnt_s    = 1'b0;
         strip_gnt_s = 1'b0;
      end
   end

   // Count fb grants that overtook a waiting strip request; saturates at the limit.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         streak_r <= 8'd0;
      end else if (!strip_req || strip_gnt_s) begin
         streak_r <= 8'd0;
      end else if (fb_gnt_s && !streak_full_s) begin
         streak_r <= streak_r + 8'd1;
      end
   end

   // Register the granted address and its owner as the RAM read command.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         ram_re_r      <= 1'b0;
         ram_raddr_r   <= {ADDR_W{1'b0}};
         issue_owner_r <= OWNER_FB;
      end else begin
         ram_re_r <= fb_gnt_s | strip_gnt_s;
         if (fb_gnt_s) begin
            ram_raddr_r   <= fb_addr;
            issue_owner_r <= OWNER_FB;
         end else if (strip_gnt_s) begin
            ram_raddr_r   <= strip_addr;
            issue_owner_r <= OWNER_STRIP;
         end
      end
   end

   assign issue_tag_s = {ram_re_r, issue_owner_r};

   read_tag_pipe #(
      .RAM_LATENCY (RAM_LATENCY)
   ) u_tag_pipe (
      .clk     (sys_clk),
      .rst     (rst),
      .tag_in  (issue_tag_s),
      .tag_out (tail_tag_s)
   );

   assign tail_fb_s    = tail_tag_s.valid && (tail_tag_s.owner == OWNER_FB);
   assign tail_strip_s = tail_tag_s.valid && (tail_tag_s.owner == OWNER_STRIP);

   // Steer the returning RAM word to its owner; the other side keeps its data.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         fb_rvalid_r    <= 1'b0;
         strip_rvalid_r <= 1'b0;
         fb_rdata_r     <= {DATA_W{1'b0}};
         strip_rdata_r  <= {DATA_W{1'b0}};
      end else begin
         fb_rvalid_r    <= tail_fb_s;
         strip_rvalid_r <= tail_strip_s;
         if (tail_fb_s) begin
            fb_rdata_r <= ram_rdata;
         end
         if (tail_strip_s) begin
            strip_rdata_r <= ram_rdata;
         end
      end
   end

   assign fb_gnt       = fb_gnt_s;
   assign strip_gnt    = strip_gnt_s;
   assign ram_re       = ram_re_r;
   assign ram_raddr    = ram_raddr_r;
   assign fb_rvalid    = fb_rvalid_r;
   assign fb_rdata     = fb_rdata_r;
   assign strip_rvalid = strip_rvalid_r;
   assign strip_rdata  = strip_rdata_r;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// tb_ram_read_arbiter
// Three arbiters (RAM_LATENCY 1, 2, 4) share one stimulus stream, each with its
// own latency-matched RAM model. A cycle model predicts grants, the issue stage
// and every return; directed sections add hand-computed checks on top.
module tb_ram_read_arbiter;
   import hub75_pkg::*;

   localparam int AW   = 15;
   localparam int DW   = 80;
   localparam int MAXS = 8;
   localparam int HN   = 1024;

   logic sys_clk = 1'b0;
   logic rst;
   logic fb_req, strip_req;
   logic [AW-1:0] fb_addr, strip_addr;

   logic          fb_gnt_a       [3];
   logic          strip_gnt_a    [3];
   logic          fb_rvalid_a    [3];
   logic          strip_rvalid_a [3];
   logic [DW-1:0] fb_rdata_a     [3];
   logic [DW-1:0] strip_rdata_a  [3];
   logic          ram_re_a       [3];
   logic [AW-1:0] ram_raddr_a    [3];
   logic [DW-1:0] ram_rdata_a    [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 sys_clk = ~sys_clk;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {16'hC0DE, 1'b0, a, 1'b1, ~a, 2'b10, a ^ 15'h1234, a + 15'd7};
   endfunction

   function automatic int lat_of(input int g);
      case (g)
         0:       return 1;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : gen_dut
         localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
         logic [DW-1:0] rd_pipe [LAT];

         always @(posedge sys_clk) begin
            rd_pipe[0] <= ram_re_a[g] ? mem_word(ram_raddr_a[g]) : ~mem_word(ram_raddr_a[g]);
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         end
         assign ram_rdata_a[g] = rd_pipe[LAT-1];

         ram_read_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT), .MAX_FB_STREAK(MAXS)
         ) u_dut (
            .sys_clk      (sys_clk),
            .rst          (rst),
            .fb_req       (fb_req),
            .fb_addr      (fb_addr),
            .fb_gnt       (fb_gnt_a[g]),
            .fb_rdata     (fb_rdata_a[g]),
            .fb_rvalid    (fb_rvalid_a[g]),
            .strip_req    (strip_req),
            .strip_addr   (strip_addr),
            .strip_gnt    (strip_gnt_a[g]),
            .strip_rdata  (strip_rdata_a[g]),
            .strip_rvalid (strip_rvalid_a[g]),
            .ram_re       (ram_re_a[g]),
            .ram_raddr    (ram_raddr_a[g]),
            .ram_rdata    (ram_rdata_a[g])
         );
      end
   endgenerate

   // ---------------- cycle model ----------------
   logic          h_rv   [HN] = '{default: 1'b0};
   logic          h_own  [HN] = '{default: 1'b0};
   logic [AW-1:0] h_addr [HN] = '{default: '0};
   logic [7:0]    m_streak = 8'd0;
   logic          m_rre = 1'b0;
   logic [AW-1:0] m_raddr = '0;
   logic          m_fbv [3] = '{default: 1'b0};
   logic          m_stv [3] = '{default: 1'b0};
   logic [DW-1:0] m_fbd [3] = '{default: '0};
   logic [DW-1:0] m_std [3] = '{default: '0};
   int            cyc = 0;

   initial begin : model_check
      logic e_fb, e_st;
      int   idx;
      forever begin
         @(negedge sys_clk);
         e_fb = !rst && fb_req && (!strip_req || (m_streak < 8'(MAXS)));
         e_st = !rst && strip_req && (!fb_req || (m_streak >= 8'(MAXS)));
         for (int k = 0; k < 3; k++) begin
            check_val($sformatf("L%0d fb_gnt", lat_of(k)), fb_gnt_a[k], e_fb);
            check_val($sformatf("L%0d strip_gnt", lat_of(k)), strip_gnt_a[k], e_st);
            check_val($sformatf("L%0d ram_re", lat_of(k)), ram_re_a[k], m_rre);
            check_val($sformatf("L%0d ram_raddr", lat_of(k)), ram_raddr_a[k], m_raddr);
            check_val($sformatf("L%0d fb_rvalid", lat_of(k)), fb_rvalid_a[k], m_fbv[k]);
            check_val($sformatf("L%0d strip_rvalid", lat_of(k)), strip_rvalid_a[k], m_stv[k]);
            check_val($sformatf("L%0d fb_rdata", lat_of(k)), fb_rdata_a[k], m_fbd[k]);
            check_val($sformatf("L%0d strip_rdata", lat_of(k)), strip_rdata_a[k], m_std[k]);
         end
         if (cyc < HN) begin
            h_rv[cyc]   = e_fb | e_st;
            h_own[cyc]  = e_st ? OWNER_STRIP : OWNER_FB;
            h_addr[cyc] = e_st ? strip_addr : fb_addr;
         end
         if (rst) begin
            for (int i = (cyc > 16) ? cyc - 16 : 0; i < cyc && i < HN; i++) h_rv[i] = 1'b0;
         end
         // expectations for the next cycle
         m_rre   = e_fb | e_st;
         m_raddr = rst ? '0 : (e_fb ? fb_addr : (e_st ? strip_addr : m_raddr));
         for (int k = 0; k < 3; k++) begin
            idx = cyc - 1 - lat_of(k);
            m_fbv[k] = 1'b0;
            m_stv[k] = 1'b0;
            if (rst) begin
               m_fbd[k] = '0;
               m_std[k] = '0;
            end else if (idx >= 0 && idx < HN && h_rv[idx]) begin
               if (h_own[idx] == OWNER_STRIP) begin
                  m_stv[k] = 1'b1;
                  m_std[k] = mem_word(h_addr[idx]);
               end else begin
                  m_fbv[k] = 1'b1;
                  m_fbd[k] = mem_word(h_addr[idx]);
               end
            end
         end
         if (rst || !strip_req || e_st) m_streak = 8'd0;
         else if (e_fb && m_streak < 8'(MAXS)) m_streak = m_streak + 8'd1;
         cyc++;
      end
   end

   // One clock of stimulus; returns at the following negedge for sampling.
   task automatic drive_cycle(input logic r, input logic f, input logic s,
                              input logic [AW-1:0] fa, input logic [AW-1:0] sa);
      @(posedge sys_clk);
      #1;
      rst = r; fb_req = f; strip_req = s; fb_addr = fa; strip_addr = sa;
      @(negedge sys_clk);
   endtask

   initial begin : stimulus
      logic [47:0] pat_fb;
      logic [47:0] pat_st;
      int fb_n, st_n;
      logic exp_s;
      rst = 1'b1; fb_req = 1'b0; strip_req = 1'b0; fb_addr = '0; strip_addr = '0;

      // reset: grants held low even with both requests present
      drive_cycle(1'b1, 1'b0, 1'b0, 15'h0, 15'h0);
      drive_cycle(1'b1, 1'b1, 1'b1, 15'h0AAA, 15'h0555);
      check_val("rst_fb_gnt", fb_gnt_a[0], 1'b0);
      check_val("rst_strip_gnt", strip_gnt_a[0], 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0, 15'h0, 15'h0);
      check_val("rst_ram_re", ram_re_a[0], 1'b0);
      check_val("rst_ram_raddr", ram_raddr_a[0], 15'h0);
      check_val("rst_fb_rvalid", fb_rvalid_a[0], 1'b0);
      check_val("rst_strip_rdata", strip_rdata_a[0], 80'h0);

      // fb only, four back-to-back reads 0x0010..0x0013
      for (int j = 0; j < 8; j++) begin
         drive_cycle(1'b0, j < 4, 1'b0, 15'h0010 + 15'(j), 15'h0);
         check_val("fbonly_gnt", fb_gnt_a[0], j < 4);
         check_val("fbonly_ram_re", ram_re_a[0], (j >= 1 && j <= 4));
         if (j >= 1 && j <= 4) check_val("fbonly_raddr", ram_raddr_a[0], 15'h0010 + 15'(j - 1));
         check_val("fbonly_rvalid", fb_rvalid_a[0], (j >= 3 && j <= 6));
         if (j >= 3 && j <= 6) check_val("fbonly_rdata", fb_rdata_a[0], mem_word(15'h0010 + 15'(j - 3)));
         check_val("fbonly_strip_rvalid", strip_rvalid_a[0], 1'b0);
      end

      // strip only, single read at 0x4000
      for (int j = 0; j < 5; j++) begin
         drive_cycle(1'b0, 1'b0, j == 0, 15'h0, 15'h4000);
         if (j == 0) check_val("strip_gnt", strip_gnt_a[0], 1'b1);
         if (j == 1) check_val("strip_ram_re", ram_re_a[0], 1'b1);
         if (j == 1) check_val("strip_raddr", ram_raddr_a[0], 15'h4000);
         check_val("strip_rvalid", strip_rvalid_a[0], j == 3);
         if (j == 3) check_val("strip_rdata", strip_rdata_a[0], mem_word(15'h4000));
         check_val("strip_fb_rvalid", fb_rvalid_a[0], 1'b0);
      end

      // starvation guard: 8 fb grants then 1 strip grant, repeating
      fb_n = 0; st_n = 0;
      for (int j = 0; j < 27; j++) begin
         drive_cycle(1'b0, 1'b1, 1'b1, 15'h0200 + 15'(fb_n), 15'h0300 + 15'(st_n));
         exp_s = ((j % 9) == 8);
         check_val("starve_strip_gnt", strip_gnt_a[0], exp_s);
         check_val("starve_fb_gnt", fb_gnt_a[0], !exp_s);
         if (fb_gnt_a[0]) fb_n++;
         if (strip_gnt_a[0]) st_n++;
      end
      for (int j = 0; j < 8; j++) drive_cycle(1'b0, 1'b0, 1'b0, 15'h0, 15'h0);

      // counter clear: strip_req drops after 5 fb grants, then 8 more fb first
      for (int j = 0; j < 15; j++) begin
         drive_cycle(1'b0, 1'b1, j != 5, 15'h0400 + 15'(fb_n), 15'h0500 + 15'(st_n));
         check_val("clear_strip_gnt", strip_gnt_a[0], j == 14);
         check_val("clear_fb_gnt", fb_gnt_a[0], j != 14);
         if (fb_gnt_a[0]) fb_n++;
         if (strip_gnt_a[0]) st_n++;
      end
      for (int j = 0; j < 8; j++) drive_cycle(1'b0, 1'b0, 1'b0, 15'h0, 15'h0);

      // reset one cycle after a grant: the read never returns
      for (int j = 0; j < 8; j++) begin
         drive_cycle(j == 1, j == 0, 1'b0, 15'h0123, 15'h0);
         if (j == 0) check_val("midrst_gnt", fb_gnt_a[0], 1'b1);
         if (j == 1) check_val("midrst_ram_re", ram_re_a[0], 1'b1);
         if (j == 1) check_val("midrst_raddr", ram_raddr_a[0], 15'h0123);
         if (j == 2) begin
            check_val("midrst_ram_re0", ram_re_a[0], 1'b0);
            check_val("midrst_raddr0", ram_raddr_a[0], 15'h0);
            check_val("midrst_fb_rdata0", fb_rdata_a[0], 80'h0);
            check_val("midrst_strip_rdata0", strip_rdata_a[0], 80'h0);
         end
         for (int k = 0; k < 3; k++) begin
            check_val($sformatf("midrst_fb_rvalid L%0d", lat_of(k)), fb_rvalid_a[k], 1'b0);
            check_val($sformatf("midrst_strip_rvalid L%0d", lat_of(k)), strip_rvalid_a[k], 1'b0);
         end
      end

      // latency sweep: fixed interleaved request pattern, model checks returns
      pat_fb = 48'hB53CE19A67D2;
      pat_st = 48'h6EA51FC3983B;
      for (int j = 0; j < 48; j++) begin
         drive_cycle(1'b0, pat_fb[j], pat_st[j], 15'h1000 + 15'(fb_n), 15'h6000 + 15'(st_n));
         if (fb_gnt_a[0]) fb_n++;
         if (strip_gnt_a[0]) st_n++;
      end
      for (int j = 0; j < 10; j++) drive_cycle(1'b0, 1'b0, 1'b0, 15'h0, 15'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
